// File: rtl/page_fault_handler.sv
// Page-fault service responder: allocates a physical frame (free list first, FIFO
// victim once full), models a fixed page-load delay and returns an installable leaf PTE.
module page_fault_handler #(
  parameter int VA_WIDTH        = 32,
  parameter int NUM_FRAMES      = 256,
  parameter int FRAME_BITS      = 8,
  parameter int SERVICE_LATENCY = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    page_fault,
  input  logic [VA_WIDTH-1:0]     fault_addr,
  input  logic [1:0]              fault_type,
  input  logic                    default_user,
  output logic                    fault_handled,
  output logic [31:0]             new_pte,
  output logic                    busy,
  output logic                    evict_valid,
  output logic [FRAME_BITS-1:0]   evict_frame,
  output logic [VA_WIDTH-13:0]    evict_vpn,
  output logic [31:0]             handled_count,
  output logic [31:0]             evict_count
);

  localparam int VPN_BITS = VA_WIDTH - 12;
  localparam int CNT_BITS = $clog2(SERVICE_LATENCY + 1);

  typedef enum logic [2:0] {IDLE, SELECT, LOAD, RESPOND, WAIT_CLEAR} state_t;

  state_t                state;
  logic [FRAME_BITS:0]   free_ptr;
  logic [FRAME_BITS-1:0] victim_ptr;
  logic [FRAME_BITS-1:0] frame;
  logic [VPN_BITS-1:0]   vpn;
  logic                  is_write;
  logic [CNT_BITS-1:0]   load_cnt;
  logic [VPN_BITS-1:0]   revmap [NUM_FRAMES];
  logic                  mem_full;
  logic [FRAME_BITS-1:0] alloc_frame;
  logic                  unused_offset;

  // free_ptr saturates at NUM_FRAMES, a power of two, so its MSB flags exhaustion
  assign mem_full      = free_ptr[FRAME_BITS];
  assign alloc_frame   = mem_full ? victim_ptr : free_ptr[FRAME_BITS-1:0];
  assign unused_offset = ^fault_addr[11:0];

  always_ff @(posedge clk) begin
    if (state == SELECT) revmap[alloc_frame] <= vpn;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      free_ptr      <= '0;
      victim_ptr    <= '0;
      frame         <= '0;
      vpn           <= '0;
      is_write      <= 1'b0;
      load_cnt      <= '0;
      fault_handled <= 1'b0;
      new_pte       <= '0;
      busy          <= 1'b0;
      evict_valid   <= 1'b0;
      evict_frame   <= '0;
      evict_vpn     <= '0;
      handled_count <= '0;
      evict_count   <= '0;
    end else begin
      fault_handled <= 1'b0;
      evict_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (page_fault) begin
            vpn      <= fault_addr[VA_WIDTH-1:12];
            is_write <= (fault_type == 2'b10);
            state    <= SELECT;
            busy     <= 1'b1;
          end
        end
        SELECT: begin
          // Allocation commits even if the fault is withdrawn here; there is no rollback
          frame    <= alloc_frame;
          load_cnt <= CNT_BITS'(SERVICE_LATENCY);
          if (!mem_full) begin
            free_ptr <= free_ptr + (FRAME_BITS+1)'(1);
          end else begin
            victim_ptr  <= victim_ptr + FRAME_BITS'(1);
            evict_valid <= 1'b1;
            evict_frame <= alloc_frame;
            evict_vpn   <= revmap[alloc_frame];
            evict_count <= evict_count + 32'd1;
          end
          if (page_fault) begin
            state <= LOAD;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LOAD: begin
          if (!page_fault) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (load_cnt == CNT_BITS'(1)) begin
            state         <= RESPOND;
            fault_handled <= 1'b1;
            new_pte       <= {{(20-FRAME_BITS){1'b0}}, frame, 7'b0, default_user,
                              1'b0, is_write, 2'b11};
            handled_count <= handled_count + 32'd1;
            load_cnt      <= load_cnt - CNT_BITS'(1);
          end else begin
            load_cnt <= load_cnt - CNT_BITS'(1);
          end
        end
        RESPOND: begin
          state <= WAIT_CLEAR;
        end
        WAIT_CLEAR: begin
          if (!page_fault) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_page_fault_handler.sv
// Self-checking bench for page_fault_handler: directed scenarios plus random faults
// checked against a FIFO-of-resident-pages reference model.
module tb_page_fault_handler;

  localparam int VA  = 32;
  localparam int NF  = 4;
  localparam int FB  = 2;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          page_fault;
  logic [VA-1:0] fault_addr;
  logic [1:0]    fault_type;
  logic          default_user;
  logic          fault_handled;
  logic [31:0]   new_pte;
  logic          busy;
  logic          evict_valid;
  logic [FB-1:0] evict_frame;
  logic [VA-13:0] evict_vpn;
  logic [31:0]   handled_count;
  logic [31:0]   evict_count;

  page_fault_handler #(
    .VA_WIDTH(VA), .NUM_FRAMES(NF), .FRAME_BITS(FB), .SERVICE_LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .page_fault(page_fault), .fault_addr(fault_addr),
    .fault_type(fault_type), .default_user(default_user),
    .fault_handled(fault_handled), .new_pte(new_pte), .busy(busy),
    .evict_valid(evict_valid), .evict_frame(evict_frame), .evict_vpn(evict_vpn),
    .handled_count(handled_count), .evict_count(evict_count)
  );

  always #5 clk = ~clk;

  typedef struct {int frame; int vpn;} res_t;

  res_t        resident[$];
  int          model_handled = 0;
  int          model_evict   = 0;
  logic [31:0] model_pte     = '0;
  int          asserts_evaluated = 0;
  int          failures          = 0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    asserts_evaluated++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Resident pages kept in allocation order; the oldest is reclaimed once all frames are used
  task automatic modelFault(input int vpn, output int frame, output bit ev,
                            output int ev_frame, output int ev_vpn);
    res_t victim;
    ev = 1'b0; ev_frame = 0; ev_vpn = 0;
    if (resident.size() < NF) begin
      frame = resident.size();
    end else begin
      victim   = resident.pop_front();
      frame    = victim.frame;
      ev       = 1'b1;
      ev_frame = victim.frame;
      ev_vpn   = victim.vpn;
      model_evict++;
    end
    resident.push_back('{frame, vpn});
  endtask

  task automatic applyStimulus(input int vpn, input logic [1:0] ftype, input logic user,
                               input bit abort, input int hold);
    int          frame, ev_frame, ev_vpn;
    bit          ev;
    int          handled_pulses = 0, handled_at = 0, evict_pulses = 0, both = 0;
    logic [31:0] pte_seen = 'x;
    logic [31:0] ev_frame_seen = 'x, ev_vpn_seen = 'x;
    logic [19:0] vpn20;
    modelFault(vpn, frame, ev, ev_frame, ev_vpn);
    vpn20        = vpn[19:0];
    fault_addr   = {vpn20, 12'($urandom)};
    fault_type   = ftype;
    default_user = user;
    page_fault   = 1'b1;
    for (int k = 1; k <= 10 + hold; k++) begin
      @(posedge clk); #1;
      if (fault_handled) begin handled_pulses++; handled_at = k; pte_seen = new_pte; end
      if (evict_valid) begin
        evict_pulses++;
        ev_frame_seen = 32'(evict_frame);
        ev_vpn_seen   = 32'(evict_vpn);
      end
      if (fault_handled && evict_valid) both++;
      if (abort && k == 3) page_fault = 1'b0;
    end
    if (!abort) begin
      checkOutput("busy_wait_clear", 32'(busy), 32'd1);
      page_fault = 1'b0;
      @(posedge clk); #1;
    end
    checkOutput("busy_idle", 32'(busy), 32'd0);
    checkOutput("handled_pulses", handled_pulses, abort ? 0 : 1);
    if (!abort) begin
      model_handled++;
      model_pte = {frame[19:0], 7'b0, user, 1'b0, (ftype == 2'b10), 2'b11};
      checkOutput("latency", handled_at, LAT + 2);
      checkOutput("new_pte", pte_seen, model_pte);
    end else begin
      checkOutput("pte_held", new_pte, model_pte);
    end
    checkOutput("evict_pulses", evict_pulses, 32'(ev));
    if (ev) begin
      checkOutput("evict_frame", ev_frame_seen, ev_frame);
      checkOutput("evict_vpn", ev_vpn_seen, ev_vpn);
    end
    checkOutput("pulse_overlap", both, 0);
    checkOutput("handled_count", handled_count, model_handled);
    checkOutput("evict_count", evict_count, model_evict);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_handled"}, 32'(fault_handled), 32'd0);
    checkOutput({tag, "_pte"}, new_pte, 32'd0);
    checkOutput({tag, "_evict"}, {evict_vpn, evict_frame, 9'd0, evict_valid}, 32'd0);
    checkOutput({tag, "_hcount"}, handled_count, 32'd0);
    checkOutput({tag, "_ecount"}, evict_count, 32'd0);
  endtask

  task automatic resetMidLoad(input int vpn);
    logic [19:0] vpn20;
    vpn20        = vpn[19:0];
    fault_addr   = {vpn20, 12'h0};
    fault_type   = 2'b01;
    page_fault   = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1 checkResetOutputs("reset_mid_load");
    page_fault = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    resident.delete();
    model_handled = 0;
    model_evict   = 0;
    model_pte     = '0;
  endtask

  initial begin
    rst          = 1'b1;
    page_fault   = 1'b0;
    fault_addr   = '0;
    fault_type   = 2'b00;
    default_user = 1'b0;
    repeat (2) @(posedge clk);
    #1 checkResetOutputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill all frames, then two FIFO evictions; the second fault stays held for 20 cycles
    applyStimulus(32'h00403, 2'b10, 1'b1, 1'b0, 0);
    applyStimulus(32'h00801, 2'b01, 1'b1, 1'b0, 0);
    applyStimulus(32'h00002, 2'b01, 1'b1, 1'b0, 0);
    applyStimulus(32'h00003, 2'b11, 1'b0, 1'b0, 0);
    applyStimulus(32'h00500, 2'b10, 1'b0, 1'b0, 0);
    applyStimulus(32'h00600, 2'b01, 1'b1, 1'b0, 20);

    // Aborted fault still consumes a frame; the next one gets the following frame
    applyStimulus(32'h00700, 2'b10, 1'b1, 1'b1, 0);
    applyStimulus(32'h00701, 2'b00, 1'b1, 1'b0, 0);

    resetMidLoad(32'h00abc);
    applyStimulus(32'h00123, 2'b10, 1'b0, 1'b0, 0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus($urandom_range(0, 32'hFFFFF), 2'($urandom), 1'($urandom),
                    ($urandom_range(0, 4) == 0), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts_evaluated, failures);
    $finish;
  end

endmodule

// File: doc/page_fault_handler.md
Name: page_fault_handler

Overview:
- Responder for the virtual memory controller's page-fault interface. It stands in for the OS fault service path.
- On a fault it picks a physical frame: the next free frame, or a FIFO victim once memory is full. It then simulates a fixed page-load latency and returns a ready-to-install leaf PTE with a one-cycle fault_handled pulse.
- Reports evictions and keeps service statistics. Sits beside the controller and feeds its fault_handled and new_pte inputs.

Parameters:
VA_WIDTH, 32, virtual address width; VPN = fault_addr[VA_WIDTH-1:12]
NUM_FRAMES, 256, physical frames managed (power of two, >=2)
FRAME_BITS, 8, log2(NUM_FRAMES)
SERVICE_LATENCY, 4, cycles spent in LOAD (>=1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
page_fault  input  1  controller fault indication, level, held until serviced
fault_addr  input  VA_WIDTH  faulting virtual address, stable while page_fault high
fault_type  input  2  01 read, 10 write; other codes treated as read
default_user  input  1  value placed in PTE U bit
fault_handled  output  1  one-cycle pulse, new_pte valid this cycle
new_pte  output  32  {PPN zero-extended to 20b, 7'b0, U, X, W, R, V}
busy  output  1  high in any state other than IDLE
evict_valid  output  1  one-cycle pulse, a resident frame was reclaimed
evict_frame  output  FRAME_BITS  reclaimed frame number
evict_vpn  output  VA_WIDTH-12  VPN previously mapped to evict_frame
handled_count  output  32  completed services
evict_count  output  32  evictions performed

Behaviour:
- Reset (asynchronous, any state): state=IDLE. free_ptr=0, victim_ptr=0. Reverse map contents don't care. All outputs 0, counters 0.
- All outputs are registered.
- States: IDLE, SELECT, LOAD, RESPOND, WAIT_CLEAR.
- IDLE: if page_fault=1 at an edge, latch VPN and is_write=(fault_type==2'b10), then go to SELECT.
- SELECT (1 cycle):
  - If free_ptr<NUM_FRAMES: frame=free_ptr, free_ptr++. free_ptr saturates at NUM_FRAMES and is FRAME_BITS+1 wide.
  - Else: frame=victim_ptr, victim_ptr increments modulo NUM_FRAMES. Pulse evict_valid with evict_frame=frame and evict_vpn=revmap[frame]; evict_count++.
  - In both cases write revmap[frame]=latched VPN, load load_cnt=SERVICE_LATENCY, then go to LOAD.
- LOAD: load_cnt decrements each cycle. Stay exactly SERVICE_LATENCY cycles, then go to RESPOND.
- RESPOND (1 cycle):
  - fault_handled=1.
  - new_pte: [31:12]=frame, [11:5]=0, [4]=default_user (sampled this cycle), [3]=X=0, [2]=W=is_write, [1]=R=1, [0]=V=1.
  - handled_count++. Go to WAIT_CLEAR.
  - new_pte holds its value until the next RESPOND or reset.
- WAIT_CLEAR: stay until page_fault=0, then go to IDLE. A level fault still held after service is never serviced twice.
- Latency: page_fault sampled at edge E0 gives fault_handled high during cycle SERVICE_LATENCY+2 after E0 (6 cycles with default).
- Abort: if page_fault falls during SELECT or LOAD, go to IDLE next edge.
  - No fault_handled pulse; handled_count unchanged.
  - The frame stays consumed and revmap stays written; there is no rollback.
  - An evict pulse already issued stands.
- Eviction order is strict FIFO by allocation. After the first wrap, victim_ptr walks 0,1,..,NUM_FRAMES-1,0.
- Counters wrap at 2^32.
- evict_valid and fault_handled are never high in the same cycle.
- Reset mid-LOAD: allocation state is lost; all frames are free again.

Test Plan:
- Basic write fault: SERVICE_LATENCY=4, default_user=1, page_fault+fault_addr=0x00403ABC, type=10. Required: fault_handled pulses 6 cycles after sampling, new_pte=0x00000017, handled_count=1, busy high until page_fault drops.
- Second read fault: fault_addr=0x00801000, type=01. Required: new_pte=0x00001013 (frame 1), evict_valid never asserted.
- Exhaustion: NUM_FRAMES=4, four faults on VPNs 0x00403, 0x00801, 0x00002, 0x00003, then a fifth on VPN 0x00500. Required on the fifth: evict_valid pulse in SELECT with evict_frame=0, evict_vpn=0x00403, then new_pte[31:12]=0 and evict_count=1. A sixth fault evicts frame 1 (VPN 0x00801).
- Held level: page_fault held high 20 cycles after fault_handled. Required: exactly one pulse, state WAIT_CLEAR, return to IDLE one edge after page_fault falls.
- Abort: page_fault dropped in the second LOAD cycle. Required: no fault_handled, handled_count unchanged, busy=0 next cycle. The next fault receives the following frame number.
- Reset mid-LOAD: rst pulsed asynchronously. Required: all outputs 0 immediately. The next fault returns frame 0 (new_pte[31:12]=0).
